// File: rtl/range_filter_bank.sv
// One stage of a range-filter chain: absorbs up to SLOTS [lower,upper] ranges,
// forwards any further ranges downstream, then drops IDs falling inside a held range.
module range_filter_bank #(
  parameter int DATA_WIDTH = 64,
  parameter int SLOTS      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       upstream_sel,
  input  logic                       upstream_valid,
  input  logic                       upstream_last,
  input  logic [DATA_WIDTH-1:0]      upstream_data,
  output logic                       downstream_sel,
  output logic                       downstream_valid,
  output logic                       downstream_last,
  output logic [DATA_WIDTH-1:0]      downstream_data,
  output logic [$clog2(SLOTS+1)-1:0] slots_used,
  output logic [CNT_WIDTH-1:0]       ids_dropped,
  output logic [1:0]                 dbg_state
);

  localparam int SW = $clog2(SLOTS+1);

  // Handshake: a beat exists only while upstream_valid is high; there is no
  // backpressure, so every beat is consumed the cycle it is presented.
  typedef enum logic [1:0] {
    LOAD_LOWER     = 2'd0,
    LOAD_UPPER     = 2'd1,
    FORWARD_RANGES = 2'd2,
    FILTER_IDS     = 2'd3
  } state_t;

  state_t                r_state;
  logic [SW-1:0]         r_slots_used;
  logic [CNT_WIDTH-1:0]  r_ids_dropped;
  logic [DATA_WIDTH-1:0] r_lower [SLOTS];
  logic [DATA_WIDTH-1:0] r_upper [SLOTS];
  logic                  r_ds_sel;
  logic                  r_ds_valid;
  logic                  r_ds_last;
  logic [DATA_WIDTH-1:0] r_ds_data;

  logic                  w_match;
  logic [SW-1:0]         w_slots_inc;

  assign w_slots_inc = r_slots_used + SW'(1);

  // Only completed slots take part; an inverted range can never match.
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if ((SW'(i) < r_slots_used) && (r_lower[i] <= upstream_data) &&
          (upstream_data <= r_upper[i]))
        w_match = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= LOAD_LOWER;
      r_slots_used  <= '0;
      r_ids_dropped <= '0;
      r_ds_sel      <= 1'b0;
      r_ds_valid    <= 1'b0;
      r_ds_last     <= 1'b0;
      r_ds_data     <= '0;
    end else begin
      r_ds_valid <= 1'b0;
      r_ds_last  <= upstream_valid && upstream_sel && upstream_last;
      if (upstream_valid || upstream_sel) begin
        r_ds_sel  <= upstream_sel;
        r_ds_data <= upstream_data;
      end
      if (upstream_sel) begin
        r_ds_valid <= upstream_valid && !w_match;
        if (upstream_valid && w_match && (r_ids_dropped != '1))
          r_ids_dropped <= r_ids_dropped + CNT_WIDTH'(1);
        // A half-loaded slot is simply never counted, so it is discarded here.
        if (upstream_valid && upstream_last) begin
          r_state      <= LOAD_LOWER;
          r_slots_used <= '0;
        end else begin
          r_state <= FILTER_IDS;
        end
      end else if (upstream_valid) begin
        case (r_state)
          LOAD_LOWER: begin
            for (int i = 0; i < SLOTS; i++)
              if (SW'(i) == r_slots_used) r_lower[i] <= upstream_data;
            r_state <= LOAD_UPPER;
          end
          LOAD_UPPER: begin
            for (int i = 0; i < SLOTS; i++)
              if (SW'(i) == r_slots_used) r_upper[i] <= upstream_data;
            r_slots_used <= w_slots_inc;
            r_state      <= (w_slots_inc == SW'(SLOTS)) ? FORWARD_RANGES : LOAD_LOWER;
          end
          FORWARD_RANGES: r_ds_valid <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign downstream_sel   = r_ds_sel;
  assign downstream_valid = r_ds_valid;
  assign downstream_last  = r_ds_last;
  assign downstream_data  = r_ds_data;
  assign slots_used       = r_slots_used;
  assign ids_dropped      = r_ids_dropped;
  assign dbg_state        = r_state;

endmodule

// File: doc/range_filter_bank.md
RANGE_FILTER_BANK -- requirements
Module: range_filter_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of range bounds and ingredient IDs.
REQ-002 SHALL have parameter SLOTS, default 4, number of ranges held per unit (>=1).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the dropped-ID counter.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port upstream_sel  in  1  1: ingredient ID beat, 0: range-bound beat.
REQ-007 SHALL have port upstream_valid  in  1  beat qualifier.
REQ-008 SHALL have port upstream_last  in  1  end of batch, meaningful only on a valid ID beat.
REQ-009 SHALL have port upstream_data  in  DATA_WIDTH  bound or ID.
REQ-010 SHALL have ports downstream_sel / downstream_valid / downstream_last / downstream_data  out  1/1/1/DATA_WIDTH  same meaning, feeds next unit in chain.
REQ-011 SHALL have port slots_used  out  $clog2(SLOTS+1)  number of complete ranges held.
REQ-012 SHALL have port ids_dropped  out  CNT_WIDTH  count of IDs absorbed by this unit.

Function
REQ-013 SHALL implement states LOAD_LOWER, LOAD_UPPER, FORWARD_RANGES, FILTER_IDS; stream order is ranges as lower,upper pairs, then IDs.
REQ-014 SHALL have all downstream_* registered with exactly 1 cycle latency; no backpressure.
REQ-015 LOAD_LOWER, valid&&!sel: store data as lower of slot[slots_used], go LOAD_UPPER, downstream_valid=0.
REQ-016 LOAD_UPPER, valid&&!sel: store upper, increment slots_used; go FORWARD_RANGES if new slots_used==SLOTS else LOAD_LOWER; downstream_valid=0.
REQ-017 FORWARD_RANGES, !sel: forward sel/valid/data unchanged (later units' ranges).
REQ-018 In any state, sel=1 (valid or not) SHALL move to FILTER_IDS, and that beat SHALL be filtered the same cycle.
REQ-019 A half-loaded slot (sel=1 in LOAD_UPPER) SHALL be discarded; slots_used unchanged.
REQ-020 Filtering: downstream_valid = valid && ID outside every occupied slot; inclusive compare lower<=ID<=upper, unsigned.
REQ-021 With slots_used==0 all IDs SHALL pass.
REQ-022 A slot with lower>upper SHALL match nothing.
REQ-023 Each valid ID matching >=1 slot SHALL increment ids_dropped once; ids_dropped saturates at all-ones.
REQ-024 FILTER_IDS, valid&&!sel (malformed): beat dropped, downstream_valid=0, state held.
REQ-025 downstream_last SHALL equal registered (valid && sel && last), asserted even when the ID itself is dropped.
REQ-026 After a valid last ID beat, next state SHALL be LOAD_LOWER and slots_used SHALL become 0 (new batch); ids_dropped retained.
REQ-027 downstream_sel/data SHALL update on any cycle with upstream_valid or upstream_sel, else hold; downstream_valid/last SHALL be 0 on idle cycles.

Reset
REQ-028 On reset: state LOAD_LOWER, slots_used=0, ids_dropped=0, all downstream_* = 0, stored bounds irrelevant.
REQ-029 Reset asserted mid-operation SHALL discard all held ranges and in-flight beats; the next cycle's outputs SHALL be reset values.

Verification (DATA_WIDTH=16, SLOTS=2)
REQ-030 Ranges [3,5],[10,14], IDs 1,5,8,11,17 -> downstream valid IDs 1,8,17 each 1 cycle later; ids_dropped=2; slots_used=2.
REQ-031 Ranges [3,5],[10,14],[20,30], ID 25 -> bounds 20,30 forwarded with sel=0 valid=1; ID 25 passes.
REQ-032 No ranges, IDs 0, 0xFFFF -> both pass; slots_used=0.
REQ-033 Lower 7 only, then ID 7 -> ID 7 passes; slots_used=0.
REQ-034 Range [1,2], ID 2 with last -> downstream valid=0, last=1; then range [5,6], ID 2 -> passes, ids_dropped=1.
REQ-035 Reset during FORWARD_RANGES -> outputs 0 next cycle; subsequent ID passes with slots_used=0.
